mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the core's single-ported unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store). It accepts one access at a time, forwards it to the memory port, and returns the fixed-latency response to the owning requester. Data accesses take priority, with a starvation guard for fetch. Wrong-path fetch responses are dropped on a pipeline flush.

## Interface
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width. Byte enables are DATA_WIDTH/8 bits wide.
- `MEM_LATENCY`, default 2: the memory returns data exactly this many cycles after accepting a request. Must be ≥1.
- `STARVE_LIMIT`, default 4: maximum consecutive data grants allowed while a fetch request is waiting.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `if_req_i` in 1: fetch request. Held until granted.
- `if_addr_i` in ADDR_WIDTH: fetch address.
- `if_gnt_o` out 1: fetch request accepted this cycle.
- `if_rvalid_o` out 1: fetch response valid.
- `if_rdata_o` out DATA_WIDTH: fetch response data.
- `flush_i` in 1: pipeline flush. Cancels the in-flight fetch response.
- `dm_req_i` in 1: data request. Held until granted.
- `dm_we_i` in 1: 1 = store, 0 = load.
- `dm_be_i` in DATA_WIDTH/8: store byte enables.
- `dm_addr_i` in ADDR_WIDTH: data address.
- `dm_wdata_i` in DATA_WIDTH: store data.
- `dm_gnt_o` out 1: data request accepted.
- `dm_rvalid_o` out 1: load data valid or store acknowledge.
- `dm_rdata_o` out DATA_WIDTH: load data.
- `mem_req_o` out 1: memory request, one-cycle pulse.
- `mem_we_o` out 1: memory write enable.
- `mem_be_o` out DATA_WIDTH/8: memory byte enables.
- `mem_addr_o` out ADDR_WIDTH: memory address.
- `mem_wdata_o` out DATA_WIDTH: memory write data.
- `mem_rdata_i` in DATA_WIDTH: memory read data, sampled in the response cycle.
- `busy_o` out 1: an access is outstanding.

## Operation
- FSM states: IDLE and WAIT. There is a single outstanding access. The owner register holds IF or DM.
- An arbitration cycle is either IDLE, or WAIT with `cnt==0` (the response cycle).
- In an arbitration cycle, a winner is chosen and issued combinationally in the same cycle:
  - `mem_req_o=1`; the memory bus is driven from the winner; the winner's `gnt=1`.
  - Next state: WAIT, with `cnt` loaded to MEM_LATENCY-1.
  - With no request: next state IDLE.
- In WAIT with `cnt!=0`: `cnt` decrements. No grants are issued and `mem_req_o=0`.
- Response cycle (WAIT, `cnt==0`):
  - The owner's `rvalid=1`.
  - `rdata` = `mem_rdata_i` for loads and fetches, and 0 for stores.
  - A new issue may occur in the same cycle.
- Priority:
  - If only one requester is active, it wins.
  - If both are active, DM wins, unless `starve_cnt==STARVE_LIMIT`; then IF wins.
- `starve_cnt`:
  - Increments on each DM grant made while `if_req_i=1`.
  - Clears on an IF grant, or whenever `if_req_i=0`.
  - Saturates at STARVE_LIMIT.
- Flush:
  - `flush_i=1` in the IF issue cycle, any WAIT cycle, or the response cycle of an IF-owned access sets `drop`.
  - With `drop` set, `if_rvalid_o` is suppressed in the response cycle. `drop` clears when that response cycle ends.
  - DM accesses are never dropped.
  - `flush_i` does not block a new grant in the same cycle.
- Drive rules:
  - `rdata` outputs are 0 whenever the corresponding `rvalid` is 0.
  - Memory bus outputs are 0 when `mem_req_o=0`.
  - `busy_o` = (state==WAIT).

## Timing
- Reset (`rst=0`) takes effect immediately:
  - State IDLE; `cnt`, `starve_cnt`, `drop` and owner are cleared.
  - All outputs are 0.
  - A memory response that lands after reset released is ignored.
- Grant latency is 0 cycles from request in an arbitration cycle.
- Response arrives MEM_LATENCY cycles after grant. Sustained throughput is one access per MEM_LATENCY cycles.
- MEM_LATENCY=1: WAIT lasts one cycle, which is the response cycle. Back-to-back issue occurs every cycle.
- Inputs must be stable in the grant cycle only. Requesters deassert `req` the cycle after `gnt`, or hold it for a further access.

## Test plan
- **Solo fetch**, MEM_LATENCY=2: `if_req_i` at cycle 0 with `if_addr_i=0x100` → `if_gnt_o` and `mem_req_o` with addr 0x100 at cycle 0. With `mem_rdata_i=0x00000013` at cycle 2 → `if_rvalid_o=1`, `if_rdata_o=0x13` at cycle 2. `busy_o` is 1 in cycles 1–2.
- **Simultaneous requests**: IF 0x200 and DM load 0x1000 at cycle 0:
  - `dm_gnt_o` at 0 and `dm_rvalid_o` at 2.
  - `if_gnt_o` at 2 with `mem_addr_o=0x200`, and `if_rvalid_o` at 4.
- **Starvation**: STARVE_LIMIT=4, both requests held continuously → DM grants at cycles 0, 2, 4, 6; IF grant at cycle 8; DM grant again at cycle 10.
- **Flush**: fetch granted at cycle 0, `flush_i` pulsed at cycle 1 → no `if_rvalid_o` at cycle 2. A DM load granted at cycle 2 returns normally at cycle 4.
- **Store**: `dm_we_i=1`, `dm_be_i=4'b0011`, addr 0x2004, wdata 0xDEADBEEF → `mem_we_o=1` and `mem_be_o=4'b0011` at cycle 0; `dm_rvalid_o=1` with `dm_rdata_o=0` at cycle 2.
- **Reset mid-access**: fetch granted at cycle 0, `rst=0` asserted mid-cycle 1 → all outputs are 0 immediately. After release, no `if_rvalid_o` appears, and a new request is granted in the first cycle it is presented.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency unified memory port between fetch (IF) and load/store (DM).
// Latency: gnt and mem_req in the arbitration cycle (0 cycles); response exactly MEM_LATENCY cycles later.
// Backpressure: one outstanding access; a requester that is not granted holds req until its gnt pulses.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  // fetch side
  input  logic                      if_req_i,
  input  logic [ADDR_WIDTH-1:0]     if_addr_i,
  output logic                      if_gnt_o,
  output logic                      if_rvalid_o,
  output logic [DATA_WIDTH-1:0]     if_rdata_o,
  input  logic                      flush_i,
  // load/store side
  input  logic                      dm_req_i,
  input  logic                      dm_we_i,
  input  logic [DATA_WIDTH/8-1:0]   dm_be_i,
  input  logic [ADDR_WIDTH-1:0]     dm_addr_i,
  input  logic [DATA_WIDTH-1:0]     dm_wdata_i,
  output logic                      dm_gnt_o,
  output logic                      dm_rvalid_o,
  output logic [DATA_WIDTH-1:0]     dm_rdata_o,
  // memory port
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  output logic                      busy_o
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(MEM_LATENCY - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic { IDLE, WAIT } state_e;
  typedef enum logic { OWN_IF, OWN_DM } owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            drop_q, drop_d;
  logic            store_q, store_d;

  logic            arb_cycle;
  logic            resp_cycle;
  logic            win_if;
  logic            win_dm;

  // Pick this cycle's winner; only the free port or the response cycle can accept a new access.
  always_comb begin
    arb_cycle  = (state_q == IDLE) || (cnt_q == '0);
    resp_cycle = (state_q == WAIT) && (cnt_q == '0);
    win_if     = 1'b0;
    win_dm     = 1'b0;
    if (arb_cycle) begin
      if (if_req_i && dm_req_i) begin
        // Data normally wins; a fetch that has been passed over STARVE_LIMIT times takes the port.
        if (starve_q == STARVE_MAX) begin
          win_if = 1'b1;
        end else begin
          win_dm = 1'b1;
        end
      end else begin
        win_if = if_req_i;
        win_dm = dm_req_i;
      end
    end
  end

  // FSM next state, latency countdown, owner bookkeeping, flush drop and starvation counter.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    drop_d   = drop_q;
    store_d  = store_q;

    if ((state_q == WAIT) && !resp_cycle) begin
      cnt_d = cnt_q - CW'(1);
      // A flush while a fetch is in flight marks its response as wrong-path.
      if ((owner_q == OWN_IF) && flush_i) begin
        drop_d = 1'b1;
      end
    end

    if (resp_cycle) begin
      state_d = IDLE;
      drop_d  = 1'b0;
    end

    // A new issue overrides the response-cycle return to IDLE (back-to-back accesses).
    if (win_if || win_dm) begin
      state_d = WAIT;
      cnt_d   = CNT_LOAD;
      owner_d = win_if ? OWN_IF : OWN_DM;
      store_d = win_dm && dm_we_i;
      drop_d  = win_if && flush_i;
    end

    if (win_if || !if_req_i) begin
      starve_d = '0;
    end else if (win_dm && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // State registers; reset abandons any in-flight access so a late memory response is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      cnt_q    <= '0;
      starve_q <= '0;
      drop_q   <= 1'b0;
      store_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
      store_q  <= store_d;
    end
  end

  // Output drive: idle buses are zero, and everything is held quiet while reset is asserted.
  always_comb begin
    if_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    dm_gnt_o    = 1'b0;
    dm_rvalid_o = 1'b0;
    dm_rdata_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    busy_o      = 1'b0;

    if (rst) begin
      if_gnt_o  = win_if;
      dm_gnt_o  = win_dm;
      mem_req_o = win_if || win_dm;
      if (win_dm) begin
        mem_we_o    = dm_we_i;
        mem_be_o    = dm_be_i;
        mem_addr_o  = dm_addr_i;
        mem_wdata_o = dm_wdata_i;
      end else if (win_if) begin
        mem_addr_o  = if_addr_i;
      end

      if (resp_cycle) begin
        if (owner_q == OWN_IF) begin
          // A flush landing in the response cycle itself also kills the fetch data.
          if (!(drop_q || flush_i)) begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rdata_i;
          end
        end else begin
          dm_rvalid_o = 1'b1;
          if (!store_q) begin
            dm_rdata_o = mem_rdata_i;
          end
        end
      end

      busy_o = (state_q == WAIT);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a timestamp-based reference model checked every cycle.
// Latency: inputs driven 1 time unit after posedge; model compare on negedge; literal checks at posedge+3.
// Backpressure: requesters hold req until their gnt, then drop it the following cycle.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic          if_gnt_o, if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          flush_i = 1'b0;
  logic          dm_req_i = 1'b0;
  logic          dm_we_i = 1'b0;
  logic [3:0]    dm_be_i = '0;
  logic [AW-1:0] dm_addr_i = '0;
  logic [DW-1:0] dm_wdata_i = '0;
  logic          dm_gnt_o, dm_rvalid_o;
  logic [DW-1:0] dm_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          busy_o;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .flush_i(flush_i),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o),
    .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding access tracked by its absolute due cycle.
  int mcyc     = 0;
  bit m_out    = 1'b0;
  bit m_own_if = 1'b0;
  bit m_store  = 1'b0;
  bit m_drop   = 1'b0;
  int m_due    = 0;
  int m_streak = 0;

  initial begin : model
    bit arb, resp, w_if, w_dm, e_irv, e_drv;
    while (!done) begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_ctl", {if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, mem_req_o, mem_we_o,
                        mem_be_o, busy_o}, 64'd0);
        chk("rst_rdata", {if_rdata_o, dm_rdata_o}, 64'd0);
        chk("rst_bus", {mem_addr_o, mem_wdata_o}, 64'd0);
        m_out    = 1'b0;
        m_drop   = 1'b0;
        m_streak = 0;
      end else begin
        arb  = !m_out || (mcyc == m_due);
        resp = m_out && (mcyc == m_due);
        w_if = 1'b0;
        w_dm = 1'b0;
        if (arb) begin
          if (if_req_i && dm_req_i) begin
            w_if = (m_streak >= LIM);
            w_dm = !w_if;
          end else begin
            w_if = if_req_i;
            w_dm = dm_req_i;
          end
        end
        e_irv = resp && m_own_if && !(m_drop || flush_i);
        e_drv = resp && !m_own_if;

        chk("if_gnt", if_gnt_o, w_if);
        chk("dm_gnt", dm_gnt_o, w_dm);
        chk("mem_req", mem_req_o, w_if || w_dm);
        chk("mem_we", mem_we_o, w_dm && dm_we_i);
        chk("mem_be", mem_be_o, w_dm ? dm_be_i : 4'd0);
        chk("mem_addr", mem_addr_o, w_dm ? dm_addr_i : (w_if ? if_addr_i : 32'd0));
        chk("mem_wdata", mem_wdata_o, w_dm ? dm_wdata_i : 32'd0);
        chk("if_rvalid", if_rvalid_o, e_irv);
        chk("if_rdata", if_rdata_o, e_irv ? mem_rdata_i : 32'd0);
        chk("dm_rvalid", dm_rvalid_o, e_drv);
        chk("dm_rdata", dm_rdata_o, (e_drv && !m_store) ? mem_rdata_i : 32'd0);
        chk("busy", busy_o, m_out);

        if (m_out && !resp && m_own_if && flush_i) m_drop = 1'b1;
        if (resp) begin
          m_out  = 1'b0;
          m_drop = 1'b0;
        end
        if (w_if || w_dm) begin
          m_out    = 1'b1;
          m_own_if = w_if;
          m_store  = w_dm && dm_we_i;
          m_due    = mcyc + LAT;
          m_drop   = w_if && flush_i;
        end
        if (w_if || !if_req_i) m_streak = 0;
        else if (w_dm)         m_streak = (m_streak + 1 > LIM) ? LIM : m_streak + 1;
      end
      mcyc++;
    end
  end

  task automatic step(input logic ireq, input logic [31:0] iaddr, input logic fl,
                      input logic dreq, input logic we, input logic [3:0] be,
                      input logic [31:0] daddr, input logic [31:0] wd, input logic [31:0] rd);
    @(posedge clk);
    #1;
    if_req_i    = ireq;
    if_addr_i   = iaddr;
    flush_i     = fl;
    dm_req_i    = dreq;
    dm_we_i     = we;
    dm_be_i     = be;
    dm_addr_i   = daddr;
    dm_wdata_i  = wd;
    mem_rdata_i = rd;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : stim
    // Reset with both requests raised: nothing may leak out.
    if_req_i = 1'b1;
    dm_req_i = 1'b1;
    #3;
    chk("reset_gnts", {if_gnt_o, dm_gnt_o, mem_req_o, busy_o}, 64'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    idle(1);

    // Solo fetch
    step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    #2 chk("solo_gnt", {if_gnt_o, mem_req_o}, 64'h3);
    chk("solo_addr", mem_addr_o, 64'h100);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 chk("solo_busy1", {busy_o, mem_req_o}, 64'h2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h13);
    #2 chk("solo_rvalid", {if_rvalid_o, busy_o}, 64'h3);
    chk("solo_rdata", if_rdata_o, 64'h13);
    idle(1);
    #2 chk("solo_busy_end", busy_o, 64'h0);

    // Simultaneous requests: DM first, IF issued in DM's response cycle
    step(1, 32'h200, 0, 1, 0, 0, 32'h1000, 0, 0);
    #2 chk("simul_dm_gnt", {dm_gnt_o, if_gnt_o}, 64'h2);
    step(1, 32'h200, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h200, 0, 0, 0, 0, 0, 0, 32'hAAAA5555);
    #2 chk("simul_dm_rsp", {dm_rvalid_o, dm_rdata_o}, {1'b1, 32'hAAAA5555});
    chk("simul_if_gnt", {if_gnt_o, mem_addr_o}, {1'b1, 32'h200});
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h1234);
    #2 chk("simul_if_rsp", {if_rvalid_o, if_rdata_o}, {1'b1, 32'h1234});
    idle(1);

    // Starvation guard: both held; DM at 0,2,4,6,10 and IF at 8
    for (int i = 0; i < 11; i++) begin
      step(1, 32'h300, 0, 1, 0, 0, 32'h4000, 0, i);
      #2 chk("starve_dm_gnt", dm_gnt_o, (i % 2 == 0) && (i != 8));
      chk("starve_if_gnt", if_gnt_o, i == 8);
    end
    idle(3);

    // Flush of an in-flight fetch; DM issued in the dropped response cycle
    step(1, 32'h400, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 32'h1008, 0, 32'h55);
    #2 chk("flush_no_rvalid", {if_rvalid_o, if_rdata_o}, 64'h0);
    chk("flush_dm_gnt", dm_gnt_o, 64'h1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h77);
    #2 chk("flush_dm_rsp", {dm_rvalid_o, dm_rdata_o}, {1'b1, 32'h77});
    idle(1);

    // Store
    step(0, 0, 0, 1, 1, 4'b0011, 32'h2004, 32'hDEADBEEF, 0);
    #2 chk("store_bus", {mem_req_o, mem_we_o, mem_be_o}, 64'h33);
    chk("store_data", {mem_addr_o, mem_wdata_o}, {32'h2004, 32'hDEADBEEF});
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF);
    #2 chk("store_ack", {dm_rvalid_o, dm_rdata_o}, {1'b1, 32'h0});
    idle(1);

    // Reset mid-access: stale response never surfaces, new fetch granted at once
    step(1, 32'h500, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h600, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1 chk("midrst_ctl", {if_gnt_o, if_rvalid_o, mem_req_o, busy_o}, 64'h0);
    chk("midrst_bus", mem_addr_o, 64'h0);
    step(1, 32'h600, 0, 0, 0, 0, 0, 0, 32'h99);
    rst = 1'b1;
    #2 chk("postrst_gnt", {if_gnt_o, mem_addr_o}, {1'b1, 32'h600});
    chk("postrst_no_stale", if_rvalid_o, 64'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h66);
    #2 chk("postrst_rsp", {if_rvalid_o, if_rdata_o}, {1'b1, 32'h66});
    idle(2);

    done = 1'b1;
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
